// File: rtl/systolic_pkg.sv
// Shared types and fixed-point helpers for systolic_mm_engine.
// Define SYSTOLIC_SAT_EN for saturating mul/add; otherwise results wrap modulo 2^nbits.
package systolic_pkg;

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, OUTPUT} state_e;

   // widest data width the helpers accept
   localparam int FX_W = 32;

   function automatic logic signed [63:0] fx_fit(input logic signed [63:0] v, input int nbits);
      logic signed [63:0] r;
`ifdef SYSTOLIC_SAT_EN
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (nbits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (nbits - 1));
      r  = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
      r = (v <<< (64 - nbits)) >>> (64 - nbits);
`endif
      return r;
   endfunction

   function automatic logic signed [63:0] fx_mul(input logic signed [FX_W-1:0] x,
                                                 input logic signed [FX_W-1:0] w,
                                                 input int nbits, input int dbits);
      logic signed [63:0] xe, we;
      xe = x;
      we = w;
      return fx_fit((xe * we) >>> dbits, nbits);
   endfunction

   function automatic logic signed [63:0] fx_add(input logic signed [FX_W-1:0] a,
                                                 input logic signed [FX_W-1:0] b,
                                                 input int nbits);
      logic signed [63:0] ae, be;
      ae = a;
      be = b;
      return fx_fit(ae + be, nbits);
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: registers x rightward and w downward,
// accumulates the fixed-point product of the operands it sees this cycle.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int NBITS = 16,
   parameter int DBITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [NBITS-1:0] x_in,
   input  logic [NBITS-1:0] w_in,
   output logic [NBITS-1:0] x_out,
   output logic [NBITS-1:0] w_out,
   output logic [NBITS-1:0] acc
);

   logic [NBITS-1:0] x_d, x_q, w_d, w_q, acc_d, acc_q, mul_v;

   always_comb begin
      mul_v = NBITS'(fx_mul(FX_W'($signed(x_in)), FX_W'($signed(w_in)), NBITS, DBITS));
      x_d   = x_q;
      w_d   = w_q;
      acc_d = acc_q;
      if (clr) begin
         x_d   = '0;
         w_d   = '0;
         acc_d = '0;
      end else if (en) begin
         x_d   = x_in;
         w_d   = w_in;
         acc_d = NBITS'(fx_add(FX_W'($signed(acc_q)), FX_W'($signed(mul_v)), NBITS));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         w_q   <= '0;
         acc_q <= '0;
      end else begin
         x_q   <= x_d;
         w_q   <= w_d;
         acc_q <= acc_d;
      end
   end

   assign x_out = x_q;
   assign w_out = w_q;
   assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Job-based ROWS x COLS output-stationary systolic matrix multiply with streamed row readout.
// Optional SYSTOLIC_SAT_EN selects saturating arithmetic in every PE.
module systolic_mm_engine
   import systolic_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int NBITS = 16,
   parameter int DBITS = 8,
   parameter int KMAX  = 255,
   parameter int KBITS = $clog2(KMAX + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [KBITS-1:0]            cfg_k,
   input  logic                        cfg_val,
   output logic                        cfg_rdy,
   input  logic [ROWS-1:0][NBITS-1:0]  x_recv_msg,
   input  logic                        x_recv_val,
   output logic                        x_recv_rdy,
   input  logic [COLS-1:0][NBITS-1:0]  w_recv_msg,
   input  logic                        w_recv_val,
   output logic                        w_recv_rdy,
   output logic [COLS-1:0][NBITS-1:0]  out_send_msg,
   output logic                        out_send_val,
   input  logic                        out_send_rdy,
   output logic                        busy
);

   localparam int DRAIN_LEN = ROWS + COLS - 1;
   localparam int DW        = $clog2(ROWS + COLS);
   localparam int RBITS     = (ROWS > 1) ? $clog2(ROWS) : 1;

   state_e            state_d, state_q;
   logic [KBITS-1:0]  k_d, k_q, kcnt_d, kcnt_q, kcnt_inc;
   logic [DW-1:0]     dcnt_d, dcnt_q;
   logic [RBITS-1:0]  rcnt_d, rcnt_q;
   logic              beat, adv, clr;

   logic [ROWS-1:0][NBITS-1:0]            x_inj, x_lane, x_edge;
   logic [COLS-1:0][NBITS-1:0]            w_inj, w_lane, w_edge;
   logic [ROWS-1:0][COLS-1:0][NBITS-1:0]  x_pass, w_pass, acc;
   logic                                  pass_unused;

   assign beat     = (state_q == COMPUTE) && x_recv_val && w_recv_val;
   assign adv      = (state_q == COMPUTE) || (state_q == DRAIN);
   assign clr      = (state_q == IDLE) && cfg_val;
   assign kcnt_inc = kcnt_q + KBITS'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         kcnt_q  <= '0;
         dcnt_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         kcnt_q  <= kcnt_d;
         dcnt_q  <= dcnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cfg_val) state_d = (cfg_k == '0) ? DRAIN : COMPUTE;
         COMPUTE: if (beat && kcnt_inc == k_q) state_d = DRAIN;
         DRAIN:   if (dcnt_q == DW'(DRAIN_LEN - 1)) state_d = OUTPUT;
         OUTPUT:  if (out_send_rdy && rcnt_q == RBITS'(ROWS - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      k_d    = k_q;
      kcnt_d = kcnt_q;
      dcnt_d = '0;
      rcnt_d = '0;
      if (clr) begin
         k_d    = cfg_k;
         kcnt_d = '0;
      end
      if (beat) kcnt_d = kcnt_inc;
      if (state_q == DRAIN) dcnt_d = dcnt_q + DW'(1);
      if (state_q == OUTPUT) rcnt_d = out_send_rdy ? rcnt_q + RBITS'(1) : rcnt_q;
   end

   always_comb begin
      cfg_rdy      = (state_q == IDLE);
      x_recv_rdy   = (state_q == COMPUTE);
      w_recv_rdy   = (state_q == COMPUTE);
      out_send_val = (state_q == OUTPUT);
      busy         = (state_q != IDLE);
      out_send_msg = (state_q == OUTPUT) ? acc[rcnt_q] : '0;
   end

   // Non-beat cycles push zeros so bubbles add nothing to the accumulators.
   assign x_inj = beat ? x_recv_msg : '0;
   assign w_inj = beat ? w_recv_msg : '0;

   for (genvar i = 0; i < ROWS; i++) begin : g_xskew
      if (i == 0) begin : g_direct
         assign x_lane[i] = x_inj[i];
      end else begin : g_delay
         logic [i-1:0][NBITS-1:0] sk_d, sk_q;
         always_comb begin
            sk_d = sk_q;
            if (clr) sk_d = '0;
            else if (adv) begin
               sk_d[0] = x_inj[i];
               for (int s = 1; s < i; s++) sk_d[s] = sk_q[s-1];
            end
         end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sk_q <= '0;
            else     sk_q <= sk_d;
         end
         assign x_lane[i] = sk_q[i-1];
      end
   end

   for (genvar j = 0; j < COLS; j++) begin : g_wskew
      if (j == 0) begin : g_direct
         assign w_lane[j] = w_inj[j];
      end else begin : g_delay
         logic [j-1:0][NBITS-1:0] sk_d, sk_q;
         always_comb begin
            sk_d = sk_q;
            if (clr) sk_d = '0;
            else if (adv) begin
               sk_d[0] = w_inj[j];
               for (int s = 1; s < j; s++) sk_d[s] = sk_q[s-1];
            end
         end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sk_q <= '0;
            else     sk_q <= sk_d;
         end
         assign w_lane[j] = sk_q[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         logic [NBITS-1:0] x_src, w_src;
         if (j == 0) begin : g_xl
            assign x_src = x_lane[i];
         end else begin : g_xp
            assign x_src = x_pass[i][j-1];
         end
         if (i == 0) begin : g_wl
            assign w_src = w_lane[j];
         end else begin : g_wp
            assign w_src = w_pass[i-1][j];
         end
         systolic_pe #(.NBITS(NBITS), .DBITS(DBITS)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .clr   (clr),
            .x_in  (x_src),
            .w_in  (w_src),
            .x_out (x_pass[i][j]),
            .w_out (w_pass[i][j]),
            .acc   (acc[i][j])
         );
      end
   end

   // Pass outputs leaving the right and bottom edges have no consumer.
   for (genvar i = 0; i < ROWS; i++) begin : g_xedge
      assign x_edge[i] = x_pass[i][COLS-1];
   end
   for (genvar j = 0; j < COLS; j++) begin : g_wedge
      assign w_edge[j] = w_pass[ROWS-1][j];
   end
   assign pass_unused = ^{x_edge, w_edge};

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Randomized self-checking bench: 4x4 and 2x3 engines against an arithmetic matrix-product model.
module tb_systolic_mm_engine;

   localparam int NB = 16;
   localparam int KM = 255;
   localparam int KB = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [KB-1:0]        cfg_k;
   logic                 cfg_val, cfg_rdy, busy;
   logic [3:0][NB-1:0]   x_msg, w_msg, o_msg;
   logic                 x_val, x_rdy, w_val, w_rdy, o_val, o_rdy;

   logic [KB-1:0]        r_cfg_k;
   logic                 r_cfg_val, r_cfg_rdy, r_busy;
   logic [1:0][NB-1:0]   r_x_msg;
   logic [2:0][NB-1:0]   r_w_msg, r_o_msg;
   logic                 r_x_val, r_x_rdy, r_w_val, r_w_rdy, r_o_val, r_o_rdy;

   systolic_mm_engine #(.ROWS(4), .COLS(4), .NBITS(NB), .DBITS(8), .KMAX(KM)) dut (
      .clk(clk), .rst(rst), .cfg_k(cfg_k), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
      .x_recv_msg(x_msg), .x_recv_val(x_val), .x_recv_rdy(x_rdy),
      .w_recv_msg(w_msg), .w_recv_val(w_val), .w_recv_rdy(w_rdy),
      .out_send_msg(o_msg), .out_send_val(o_val), .out_send_rdy(o_rdy), .busy(busy));

   systolic_mm_engine #(.ROWS(2), .COLS(3), .NBITS(NB), .DBITS(8), .KMAX(KM)) u_rect (
      .clk(clk), .rst(rst), .cfg_k(r_cfg_k), .cfg_val(r_cfg_val), .cfg_rdy(r_cfg_rdy),
      .x_recv_msg(r_x_msg), .x_recv_val(r_x_val), .x_recv_rdy(r_x_rdy),
      .w_recv_msg(r_w_msg), .w_recv_val(r_w_val), .w_recv_rdy(r_w_rdy),
      .out_send_msg(r_o_msg), .out_send_val(r_o_val), .out_send_rdy(r_o_rdy), .busy(r_busy));

   int X [4][KM];
   int W [KM][4];
   int C [4][4];
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reduce an exact value to NB bits: clamp when saturating, else two's-complement wrap.
   function automatic longint fit(input longint v);
`ifdef SYSTOLIC_SAT_EN
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
`else
      longint t;
      t = v & 64'hFFFF;
      if (t >= 32768) t -= 65536;
      return t;
`endif
   endfunction

   function automatic longint qmul(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      return fit(p >>> 8);
   endfunction

   task automatic model(input int rows, input int cols, input int k);
      for (int i = 0; i < rows; i++)
         for (int j = 0; j < cols; j++) begin
            longint a;
            a = 0;
            for (int kk = 0; kk < k; kk++) a = fit(a + qmul(X[i][kk], W[kk][j]));
            C[i][j] = int'(a);
         end
   endtask

   function automatic logic [63:0] exp_row(input int r, input int cols);
      logic [63:0] v;
      v = '0;
      for (int j = 0; j < cols; j++) v[16*j +: 16] = 16'(C[r][j]);
      return v;
   endfunction

   function automatic int rnd16();
      logic [15:0] t;
      t = 16'($urandom);
      return int'($signed(t));
   endfunction

   task automatic fill_rand(input int k);
      for (int kk = 0; kk < k; kk++)
         for (int i = 0; i < 4; i++) begin
            X[i][kk] = rnd16();
            W[kk][i] = rnd16();
         end
   endtask

   // One 4x4 job: bub = percent chance each val is dropped, bp_row = row held 5 cycles (-1 none).
   task automatic run4(input string name, input int k, input int bub, input int bp_row);
      int idx, guard, lat;
      logic fire;
      logic [63:0] hold;
      model(4, 4, k);
      @(negedge clk);
      guard = 0;
      while (!cfg_rdy && guard < 100) begin @(negedge clk); guard++; end
      chk({name, "_cfg_rdy"}, 64'(cfg_rdy), 64'd1);
      cfg_k = KB'(k);
      cfg_val = 1'b1;
      @(negedge clk);
      cfg_val = 1'b0;
      idx = 0;
      guard = 0;
      while (idx < k && guard < 20000) begin
         x_val = ($urandom_range(99) >= bub);
         w_val = ($urandom_range(99) >= bub);
         for (int i = 0; i < 4; i++) begin
            x_msg[i] = 16'(X[i][idx]);
            w_msg[i] = 16'(W[idx][i]);
         end
         fire = x_val && w_val && x_rdy;
         @(posedge clk);
         @(negedge clk);
         if (fire) idx++;
         guard++;
      end
      chk({name, "_beats"}, 64'(idx), 64'(k));
      x_val = 1'b0;
      w_val = 1'b0;
      lat = 1;
      while (!o_val && lat < 40) begin @(negedge clk); lat++; end
      chk({name, "_latency"}, 64'(lat), 64'd8);
      for (int r = 0; r < 4; r++) begin
         o_rdy = (r != bp_row);
         chk($sformatf("%s_val%0d", name, r), 64'(o_val), 64'd1);
         chk($sformatf("%s_row%0d", name, r), 64'(o_msg), exp_row(r, 4));
         if (r == bp_row) begin
            hold = 64'(o_msg);
            repeat (5) begin
               @(posedge clk);
               @(negedge clk);
               chk({name, "_hold_val"}, 64'(o_val), 64'd1);
               chk({name, "_hold_msg"}, 64'(o_msg), hold);
            end
            o_rdy = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk({name, "_done_idle"}, {62'd0, cfg_rdy, busy}, 64'd2);
      chk({name, "_done_val"}, 64'(o_val), 64'd0);
   endtask

   task automatic run_rect(input int k);
      int idx, guard, beats;
      logic fire;
      model(2, 3, k);
      @(negedge clk);
      chk("rect_cfg_rdy", 64'(r_cfg_rdy), 64'd1);
      r_cfg_k = KB'(k);
      r_cfg_val = 1'b1;
      @(negedge clk);
      r_cfg_val = 1'b0;
      idx = 0;
      guard = 0;
      while (idx < k && guard < 1000) begin
         r_x_val = 1'b1;
         r_w_val = 1'b1;
         for (int i = 0; i < 2; i++) r_x_msg[i] = 16'(X[i][idx]);
         for (int j = 0; j < 3; j++) r_w_msg[j] = 16'(W[idx][j]);
         fire = r_x_rdy;
         @(posedge clk);
         @(negedge clk);
         if (fire) idx++;
         guard++;
      end
      r_x_val = 1'b0;
      r_w_val = 1'b0;
      beats = 0;
      repeat (40) begin
         if (r_o_val) begin
            if (beats < 2) chk($sformatf("rect_row%0d", beats), 64'(r_o_msg), exp_row(beats, 3));
            beats++;
         end
         @(negedge clk);
      end
      chk("rect_beats", 64'(beats), 64'd2);
      chk("rect_idle", 64'(r_cfg_rdy), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      cfg_k = '0; cfg_val = 1'b0; x_msg = '0; w_msg = '0; x_val = 1'b0; w_val = 1'b0; o_rdy = 1'b1;
      r_cfg_k = '0; r_cfg_val = 1'b0; r_x_msg = '0; r_w_msg = '0;
      r_x_val = 1'b0; r_w_val = 1'b0; r_o_rdy = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_recv_rdy", {62'd0, x_rdy, w_rdy}, 64'd0);
      chk("rst_out_val", 64'(o_val), 64'd0);
      chk("rst_out_msg", 64'(o_msg), 64'd0);
      rst = 1'b0;

      // identity X, W = 1..16 in 8.8
      for (int kk = 0; kk < 4; kk++)
         for (int i = 0; i < 4; i++) begin
            X[i][kk] = (i == kk) ? 256 : 0;
            W[kk][i] = (4 * kk + i + 1) * 256;
         end
      run4("ident", 4, 0, -1);
      run4("bubble", 4, 50, -1);
      run4("bprs", 4, 0, 1);

      fill_rand(7);
      run4("rand7", 7, 30, 2);

      run4("k0", 0, 0, -1);

      for (int kk = 0; kk < KM; kk++)
         for (int i = 0; i < 4; i++) begin
            X[i][kk] = 256;
            W[kk][i] = 256;
         end
      run4("kmax", KM, 0, -1);

      fill_rand(5);
      run_rect(5);

      // abort a job with reset partway through COMPUTE
      fill_rand(10);
      @(negedge clk);
      cfg_k = KB'(10);
      cfg_val = 1'b1;
      @(negedge clk);
      cfg_val = 1'b0;
      x_val = 1'b1;
      w_val = 1'b1;
      x_msg = {16'h0300, 16'h0200, 16'h0100, 16'h0400};
      w_msg = {16'h0100, 16'h0100, 16'h0200, 16'h0300};
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_cfg_rdy", 64'(cfg_rdy), 64'd1);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_recv_rdy", {62'd0, x_rdy, w_rdy}, 64'd0);
      chk("midrst_out", {47'd0, o_val, o_msg[0]}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      x_val = 1'b0;
      w_val = 1'b0;
      fill_rand(6);
      run4("postrst", 6, 20, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
